multiplicador_sequencial: RTL and testbench

Shift-and-add unsigned multiplier controller built around a single shared LARGURA-bit ripple adder (the team's 1-bit full-adder chain).
- Sequences one add/shift per clock over LARGURA cycles.
- Produces a 2*LARGURA-bit product with a start/busy/done handshake.
- Sits between the operand registers of the arithmetic unit and its result consumer.
- Replaces a combinational array multiplier where area matters.

---
 rtl/multiplicador_sequencial.sv | 128 ++++++++++++
 tb/tb_multiplicador_sequencial.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplicador_sequencial.sv
`default_nettype none
// ============================================================================
// Module   : multiplicador_sequencial
// Brief    : Shift-and-add unsigned multiplier. One add/shift per clock over
//            LARGURA cycles through a single LARGURA-bit ripple adder built
//            from a 1-bit full-adder chain. start/busy/done handshake
//            (inicio/ocupado/pronto).
//            Optional feature macro: MULT_ZERO_SKIP_EN (a zero operand
//            completes in one cycle without entering SOMA).
// Revision : 1.0 - initial release
// ============================================================================
module multiplicador_sequencial #(
  parameter int LARGURA = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   inicio,
  input  logic [LARGURA-1:0]     numero1,
  input  logic [LARGURA-1:0]     numero2,
  output logic                   ocupado,
  output logic                   pronto,
  output logic [2*LARGURA-1:0]   resultado
);

  localparam int                C_CW     = $clog2(LARGURA) + 1;
  localparam logic [C_CW-1:0]   C_ULTIMO = C_CW'(LARGURA - 1);

  typedef enum logic [0:0] {
    OCIOSO = 1'b0,
    SOMA   = 1'b1
  } estado_t;

  estado_t                state_q, state_d;
  logic [LARGURA-1:0]     m_q, m_d;
  logic [LARGURA-1:0]     q_q, q_d;
  logic [LARGURA-1:0]     a_q, a_d;
  logic [C_CW-1:0]        cnt_q, cnt_d;
  logic [2*LARGURA-1:0]   resultado_q, resultado_d;
  logic                   pronto_q, pronto_d;

  // The adder carry (C) is consumed by the shift in the same cycle it is
  // produced, so it lives only on the carry chain and needs no flop.
  logic [LARGURA-1:0]     w_parcela;
  logic [LARGURA-1:0]     w_soma;
  logic [LARGURA:0]       w_carry;
  logic                   w_atalho;

  assign w_parcela  = q_q[0] ? m_q : '0;
  assign w_carry[0] = 1'b0;

  // Ripple chain of 1-bit full adders: {carry, soma} = A + (Q[0] ? M : 0).
  for (genvar i = 0; i < LARGURA; i++) begin : g_fa
    assign w_soma[i]    = a_q[i] ^ w_parcela[i] ^ w_carry[i];
    assign w_carry[i+1] = (a_q[i] & w_parcela[i]) |
                          (w_carry[i] & (a_q[i] ^ w_parcela[i]));
  end

`ifdef MULT_ZERO_SKIP_EN
  assign w_atalho = (numero1 == '0) || (numero2 == '0);
`else
  assign w_atalho = 1'b0;
`endif

  // Next-state logic: capture on accepted start, add/shift while in SOMA,
  // publish the product on the last iteration.
  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    q_d         = q_q;
    a_d         = a_q;
    cnt_d       = cnt_q;
    resultado_d = resultado_q;
    pronto_d    = 1'b0;
    unique case (state_q)
      OCIOSO: begin
        if (inicio && w_atalho) begin
          resultado_d = '0;
          pronto_d    = 1'b1;
        end else if (inicio) begin
          m_d     = numero1;
          q_d     = numero2;
          a_d     = '0;
          cnt_d   = '0;
          state_d = SOMA;
        end
      end
      SOMA: begin
        // Logical right shift of {C, S, Q} by one position.
        a_d   = {w_carry[LARGURA], w_soma[LARGURA-1:1]};
        q_d   = {w_soma[0], q_q[LARGURA-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_ULTIMO) begin
          resultado_d = {a_d, q_d};
          pronto_d    = 1'b1;
          state_d     = OCIOSO;
        end
      end
      default: state_d = OCIOSO;
    endcase
  end

  // State register with synchronous active-low reset taking priority.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= OCIOSO;
      m_q         <= '0;
      q_q         <= '0;
      a_q         <= '0;
      cnt_q       <= '0;
      resultado_q <= '0;
      pronto_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      q_q         <= q_d;
      a_q         <= a_d;
      cnt_q       <= cnt_d;
      resultado_q <= resultado_d;
      pronto_q    <= pronto_d;
    end
  end

  assign ocupado   = (state_q == SOMA);
  assign pronto    = pronto_q;
  assign resultado = resultado_q;

endmodule
`default_nettype wire

// File: tb/tb_multiplicador_sequencial.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiplicador_sequencial
// Brief    : Self-checking bench for multiplicador_sequencial. Expected
//            products come from plain arithmetic (a*b); expected latency is
//            LARGURA cycles, or 1 cycle for zero operands when
//            MULT_ZERO_SKIP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiplicador_sequencial;

  localparam int L = 4;

  logic             clock;
  logic             reset_n;
  logic             inicio;
  logic [L-1:0]     numero1;
  logic [L-1:0]     numero2;
  logic             ocupado;
  logic             pronto;
  logic [2*L-1:0]   resultado;

  int passed;
  int total;

  multiplicador_sequencial #(.LARGURA(L)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .inicio    (inicio),
    .numero1   (numero1),
    .numero2   (numero2),
    .ocupado   (ocupado),
    .pronto    (pronto),
    .resultado (resultado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: product and latency from the arithmetic rules alone.
  function automatic logic [2*L-1:0] ref_prod(input logic [L-1:0] a, input logic [L-1:0] b);
    int unsigned p;
    p = int'(a) * int'(b);
    return p[2*L-1:0];
  endfunction

  function automatic int ref_lat(input logic [L-1:0] a, input logic [L-1:0] b);
`ifdef MULT_ZERO_SKIP_EN
    if (a == '0 || b == '0) return 0;
`endif
    return L;
  endfunction

  // Present a one-cycle start; returns at the falling edge after the start edge.
  task automatic start_op(input logic [L-1:0] a, input logic [L-1:0] b);
    @(negedge clock);
    inicio  = 1'b1;
    numero1 = a;
    numero2 = b;
    @(negedge clock);
    inicio  = 1'b0;
    numero1 = L'($urandom);
    numero2 = L'($urandom);
  endtask

  // Count edges after the start edge until pronto is seen (bounded).
  task automatic wait_pronto(output int lat);
    lat = 0;
    while (!pronto && lat < 30) begin
      @(negedge clock);
      lat++;
    end
    if (!pronto) lat = -1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    inicio  = 1'b0;
    numero1 = '0;
    numero2 = '0;
    repeat (3) @(negedge clock);
    total++; if (ocupado !== 1'b0) $display("FAIL reset_ocupado got=%b exp=0", ocupado); else passed++;
    total++; if (pronto !== 1'b0) $display("FAIL reset_pronto got=%b exp=0", pronto); else passed++;
    total++; if (resultado !== '0) $display("FAIL reset_resultado got=%h exp=00", resultado); else passed++;
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic();
    int lat;
    start_op(4'd3, 4'd5);
    lat = 0;
    for (int k = 1; k < L; k++) begin
      @(negedge clock);
      lat++;
      total++; if (ocupado !== 1'b1) $display("FAIL basic_ocupado k=%0d got=%b exp=1", k, ocupado); else passed++;
      total++; if (pronto !== 1'b0) $display("FAIL basic_early_pronto k=%0d got=%b exp=0", k, pronto); else passed++;
    end
    @(negedge clock);
    lat++;
    total++; if (pronto !== 1'b1) $display("FAIL basic_pronto got=%b exp=1", pronto); else passed++;
    total++; if (ocupado !== 1'b0) $display("FAIL basic_ocupado_end got=%b exp=0", ocupado); else passed++;
    total++; if (resultado !== 8'h0F) $display("FAIL basic_resultado got=%h exp=0f", resultado); else passed++;
  endtask

  task automatic test_max();
    int lat;
    start_op(4'hF, 4'hF);
    wait_pronto(lat);
    total++; if (lat !== L) $display("FAIL max_latency got=%0d exp=%0d", lat, L); else passed++;
    total++; if (resultado !== 8'hE1) $display("FAIL max_resultado got=%h exp=e1", resultado); else passed++;
    @(negedge clock);
    total++; if (pronto !== 1'b0) $display("FAIL max_pronto_width got=%b exp=0", pronto); else passed++;
    total++; if (resultado !== 8'hE1) $display("FAIL max_hold got=%h exp=e1", resultado); else passed++;
  endtask

  task automatic test_ignore_busy();
    int lat;
    int extra;
    start_op(4'd7, 4'd9);
    @(negedge clock);
    inicio  = 1'b1;
    numero1 = 4'd2;
    numero2 = 4'd2;
    @(negedge clock);
    inicio  = 1'b0;
    lat = 2;
    while (!pronto && lat < 30) begin
      @(negedge clock);
      lat++;
    end
    total++; if (lat !== L) $display("FAIL busy_latency got=%0d exp=%0d", lat, L); else passed++;
    total++; if (resultado !== 8'h3F) $display("FAIL busy_resultado got=%h exp=3f", resultado); else passed++;
    extra = 0;
    repeat (10) begin
      @(negedge clock);
      if (pronto) extra++;
    end
    total++; if (extra !== 0) $display("FAIL busy_second_pronto got=%0d exp=0", extra); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clock);
    inicio  = 1'b1;
    numero1 = 4'd6;
    numero2 = 4'd7;
    @(negedge clock);
    wait_pronto(lat);
    total++; if (lat !== L) $display("FAIL b2b_latency1 got=%0d exp=%0d", lat, L); else passed++;
    total++; if (resultado !== 8'h2A) $display("FAIL b2b_resultado1 got=%h exp=2a", resultado); else passed++;
    // inicio still high in the pronto cycle: accepted at the next edge.
    numero1 = 4'hA;
    numero2 = 4'hB;
    @(negedge clock);
    numero1 = '0;
    numero2 = '0;
    wait_pronto(lat);
    inicio = 1'b0;
    total++; if (lat !== L) $display("FAIL b2b_latency2 got=%0d exp=%0d", lat, L); else passed++;
    total++; if (resultado !== 8'h6E) $display("FAIL b2b_resultado2 got=%h exp=6e", resultado); else passed++;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int seen;
    start_op(4'hF, 4'hF);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    seen = (pronto === 1'b1) ? 1 : 0;
    @(negedge clock);
    reset_n = 1'b1;
    total++; if (resultado !== '0) $display("FAIL midreset_resultado got=%h exp=00", resultado); else passed++;
    total++; if (ocupado !== 1'b0) $display("FAIL midreset_ocupado got=%b exp=0", ocupado); else passed++;
    repeat (8) begin
      @(negedge clock);
      if (pronto) seen++;
    end
    total++; if (seen !== 0) $display("FAIL midreset_pronto got=%0d exp=0", seen); else passed++;
    start_op(4'd2, 4'd3);
    wait_pronto(lat);
    total++; if (lat !== L) $display("FAIL midreset_new_latency got=%0d exp=%0d", lat, L); else passed++;
    total++; if (resultado !== 8'h06) $display("FAIL midreset_new_resultado got=%h exp=06", resultado); else passed++;
  endtask

  task automatic test_zero_operand();
    int lat;
    int busy;
    busy = 0;
    start_op('0, 4'hD);
    lat = 0;
    while (!pronto && lat < 30) begin
      if (ocupado) busy++;
      @(negedge clock);
      lat++;
    end
    if (!pronto) lat = -1;
    total++; if (lat !== ref_lat('0, 4'hD)) $display("FAIL zero_latency got=%0d exp=%0d", lat, ref_lat('0, 4'hD)); else passed++;
    total++; if (resultado !== 8'h00) $display("FAIL zero_resultado got=%h exp=00", resultado); else passed++;
`ifdef MULT_ZERO_SKIP_EN
    total++; if (busy !== 0) $display("FAIL zero_ocupado got=%0d exp=0", busy); else passed++;
`endif
    repeat (2) @(negedge clock);
  endtask

  task automatic test_random();
    logic [L-1:0] a;
    logic [L-1:0] b;
    int lat;
    for (int n = 0; n < 40; n++) begin
      a = L'($urandom);
      b = L'($urandom);
      if ($urandom_range(0, 7) == 0) a = '0;
      repeat ($urandom_range(0, 2)) @(negedge clock);
      start_op(a, b);
      wait_pronto(lat);
      total++; if (lat !== ref_lat(a, b)) $display("FAIL rand_latency %0d*%0d got=%0d exp=%0d", a, b, lat, ref_lat(a, b)); else passed++;
      total++; if (resultado !== ref_prod(a, b)) $display("FAIL rand_resultado %0d*%0d got=%h exp=%h", a, b, resultado, ref_prod(a, b)); else passed++;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_basic();
    test_max();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_op();
    test_zero_operand();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
